elevator_ctrl: RTL and testbench

- Single-car elevator sequencer using the collective-SCAN policy.
- Consumes the latched call vectors from the button block and drives that block's inactivate vectors.
- Drives the motor up/down commands, the door and the current-floor indicator.
- Sits between the button latches and the car/motor/door actuators.

---
 rtl/elevator_pkg.sv | 26 ++
 rtl/elevator_req_scan.sv | 45 ++++
 rtl/elevator_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_elevator_ctrl.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/elevator_pkg.sv
// Shared state encoding, default geometry/timing and small elaboration helpers
// for the single-car collective-SCAN elevator controller.
package elevator_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MOVE_UP   = 2'd1,
        MOVE_DOWN = 2'd2,
        DOOR_OPEN = 2'd3
    } state_e;

    localparam int DEF_FLOORS        = 8;
    localparam int DEF_FLOOR_W       = 3;
    localparam int DEF_TRAVEL_CYCLES = 16;
    localparam int DEF_DOOR_CYCLES   = 32;

    function automatic int max_cycles(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // One shared timer must reach the longer of the two phase counts.
    function automatic int timer_width(input int cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/elevator_req_scan.sv
// Combinational request scan around one floor: above/below/here plus the same
// qualified by travel direction (ahead/behind, forward hall call, turnaround).
module elevator_req_scan
    import elevator_pkg::*;
#(
    parameter int FLOORS  = DEF_FLOORS,
    parameter int FLOOR_W = DEF_FLOOR_W
) (
    input  logic [FLOORS-1:0]  call_in,
    input  logic [FLOORS-1:0]  call_up,
    input  logic [FLOORS-1:0]  call_down,
    input  logic [FLOOR_W-1:0] floor,
    input  logic               dir_up,
    output logic               above,
    output logic               below,
    output logic               here,
    output logic               ahead,
    output logic               behind,
    output logic               here_fwd,
    output logic               turn
);

    logic [FLOORS-1:0] req;

    always_comb begin
        req   = call_in | call_up | call_down;
        above = 1'b0;
        below = 1'b0;
        for (int i = 0; i < FLOORS; i++) begin
            if (i > int'(floor)) above = above | req[i];
            if (i < int'(floor)) below = below | req[i];
        end
        here   = req[floor];
        ahead  = dir_up ? above : below;
        behind = dir_up ? below : above;

        // A car call or the hall call matching the travel direction is a reason to stop.
        here_fwd = call_in[floor] | (dir_up ? call_up[floor] : call_down[floor]);

        // Only the opposite hall call is waiting here and nothing lies further on.
        turn = dir_up ? (!call_up[floor]   &&  call_down[floor] && !above)
                      : (!call_down[floor] &&  call_up[floor]   && !below);
    end

endmodule

// File: rtl/elevator_ctrl.sv
// Collective-SCAN elevator sequencer; optional door hold input under ELEVATOR_DOOR_HOLD_EN.
// Latency: registered outputs, door opens 1 cycle after an at-floor call, TRAVEL_CYCLES per floor.
// Backpressure: none; call latches are cleared via level inactivate vectors while the door is open.
module elevator_ctrl
    import elevator_pkg::*;
#(
    parameter int FLOORS        = DEF_FLOORS,
    parameter int FLOOR_W       = DEF_FLOOR_W,
    parameter int TRAVEL_CYCLES = DEF_TRAVEL_CYCLES,
    parameter int DOOR_CYCLES   = DEF_DOOR_CYCLES
) (
    input  logic               clk,
    input  logic               reset,
`ifdef ELEVATOR_DOOR_HOLD_EN
    input  logic               door_hold,
`endif
    input  logic [FLOORS-1:0]  active_in_levels,
    input  logic [FLOORS-1:0]  active_out_up_levels,
    input  logic [FLOORS-1:0]  active_out_down_levels,
    output logic [FLOORS-1:0]  inactivate_in_levels,
    output logic [FLOORS-1:0]  inactivate_out_up_levels,
    output logic [FLOORS-1:0]  inactivate_out_down_levels,
    output logic [FLOOR_W-1:0] cur_floor,
    output logic               motor_up,
    output logic               motor_down,
    output logic               door_open,
    output logic               dir_up,
    output logic               busy
);

    localparam int TIMER_W = timer_width(max_cycles(TRAVEL_CYCLES, DOOR_CYCLES));
    localparam logic [TIMER_W-1:0] TRAVEL_LAST = TIMER_W'(TRAVEL_CYCLES - 1);
    localparam logic [TIMER_W-1:0] DOOR_LAST   = TIMER_W'(DOOR_CYCLES - 1);
    localparam logic [FLOOR_W-1:0] TOP_FLOOR   = FLOOR_W'(FLOORS - 1);

    state_e              state_q, state_d;
    logic [FLOOR_W-1:0]  cur_floor_q, cur_floor_d;
    logic                dir_up_q, dir_up_d;
    logic [TIMER_W-1:0]  timer_q, timer_d;
    logic                motor_up_q, motor_up_d;
    logic                motor_down_q, motor_down_d;
    logic                door_open_q, door_open_d;
    logic                busy_q, busy_d;
    logic [FLOORS-1:0]   inact_in_q, inact_in_d;
    logic [FLOORS-1:0]   inact_up_q, inact_up_d;
    logic [FLOORS-1:0]   inact_dn_q, inact_dn_d;
    logic [FLOORS-1:0]   floor_onehot;

    logic                travel_done;
    logic                door_done;
    logic                hold;
    logic [FLOOR_W-1:0]  scan_floor;
    logic                above, below, here, ahead, behind, here_fwd, turn;

`ifdef ELEVATOR_DOOR_HOLD_EN
    assign hold = door_hold;
`else
    assign hold = 1'b0;
`endif

    assign travel_done = (timer_q == TRAVEL_LAST);
    assign door_done   = (timer_q == DOOR_LAST);

    // Stop decisions are taken on the floor being arrived at, so scan one floor ahead then.
    always_comb begin
        scan_floor = cur_floor_q;
        if (state_q == MOVE_UP && travel_done && cur_floor_q != TOP_FLOOR)
            scan_floor = cur_floor_q + FLOOR_W'(1);
        else if (state_q == MOVE_DOWN && travel_done && cur_floor_q != '0)
            scan_floor = cur_floor_q - FLOOR_W'(1);
    end

    elevator_req_scan #(
        .FLOORS  (FLOORS),
        .FLOOR_W (FLOOR_W)
    ) u_scan (
        .call_in   (active_in_levels),
        .call_up   (active_out_up_levels),
        .call_down (active_out_down_levels),
        .floor     (scan_floor),
        .dir_up    (dir_up_q),
        .above     (above),
        .below     (below),
        .here      (here),
        .ahead     (ahead),
        .behind    (behind),
        .here_fwd  (here_fwd),
        .turn      (turn)
    );

    always_comb begin
        state_d     = state_q;
        cur_floor_d = cur_floor_q;
        dir_up_d    = dir_up_q;
        timer_d     = timer_q;
        case (state_q)
            IDLE: begin
                timer_d = '0;
                if (here) begin
                    state_d = DOOR_OPEN;
                    if (turn) dir_up_d = ~dir_up_q;
                end else if (above) begin
                    state_d  = MOVE_UP;
                    dir_up_d = 1'b1;
                end else if (below) begin
                    state_d  = MOVE_DOWN;
                    dir_up_d = 1'b0;
                end
            end
            MOVE_UP, MOVE_DOWN: begin
                if (!travel_done) begin
                    timer_d = timer_q + TIMER_W'(1);
                end else begin
                    timer_d     = '0;
                    cur_floor_d = scan_floor;
                    if (here_fwd || !ahead) begin
                        state_d = DOOR_OPEN;
                        if (turn) dir_up_d = ~dir_up_q;
                    end
                end
            end
            DOOR_OPEN: begin
                if (hold) begin
                    timer_d = '0;
                end else if (!door_done) begin
                    timer_d = timer_q + TIMER_W'(1);
                end else begin
                    timer_d = '0;
                    if (ahead) begin
                        state_d = dir_up_q ? MOVE_UP : MOVE_DOWN;
                    end else if (here) begin
                        // Serve the opposite-direction hall call without closing the door.
                        dir_up_d = ~dir_up_q;
                    end else if (behind) begin
                        dir_up_d = ~dir_up_q;
                        state_d  = dir_up_q ? MOVE_DOWN : MOVE_UP;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                timer_d = '0;
            end
        endcase
    end

    // Outputs are registered from the next-state view so they line up with the state.
    always_comb begin
        floor_onehot               = '0;
        floor_onehot[cur_floor_d]  = 1'b1;
        motor_up_d                 = (state_d == MOVE_UP);
        motor_down_d               = (state_d == MOVE_DOWN);
        door_open_d                = (state_d == DOOR_OPEN);
        busy_d                     = (state_d != IDLE);
        inact_in_d                 = door_open_d ? floor_onehot : '0;
        inact_up_d                 = (door_open_d &&  dir_up_d) ? floor_onehot : '0;
        inact_dn_d                 = (door_open_d && !dir_up_d) ? floor_onehot : '0;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            cur_floor_q  <= '0;
            dir_up_q     <= 1'b1;
            timer_q      <= '0;
            motor_up_q   <= 1'b0;
            motor_down_q <= 1'b0;
            door_open_q  <= 1'b0;
            busy_q       <= 1'b0;
            inact_in_q   <= '0;
            inact_up_q   <= '0;
            inact_dn_q   <= '0;
        end else begin
            state_q      <= state_d;
            cur_floor_q  <= cur_floor_d;
            dir_up_q     <= dir_up_d;
            timer_q      <= timer_d;
            motor_up_q   <= motor_up_d;
            motor_down_q <= motor_down_d;
            door_open_q  <= door_open_d;
            busy_q       <= busy_d;
            inact_in_q   <= inact_in_d;
            inact_up_q   <= inact_up_d;
            inact_dn_q   <= inact_dn_d;
        end
    end

    assign inactivate_in_levels       = inact_in_q;
    assign inactivate_out_up_levels   = inact_up_q;
    assign inactivate_out_down_levels = inact_dn_q;
    assign cur_floor                  = cur_floor_q;
    assign motor_up                   = motor_up_q;
    assign motor_down                 = motor_down_q;
    assign door_open                  = door_open_q;
    assign dir_up                     = dir_up_q;
    assign busy                       = busy_q;

endmodule

// File: tb/tb_elevator_ctrl.sv
// Bench for elevator_ctrl: models the button latches (press wins over clear),
// checks stops against a scoreboard queue plus per-cycle output invariants.
module tb_elevator_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] cin, cup, cdn;
    logic [7:0] inact_in, inact_up, inact_dn;
    logic [2:0] cur_floor;
    logic       motor_up, motor_down, door_open, dir_up, busy;
`ifdef ELEVATOR_DOOR_HOLD_EN
    logic       door_hold;
`endif

    always #5 clk = ~clk;

    elevator_ctrl dut (
        .clk                        (clk),
        .reset                      (reset),
`ifdef ELEVATOR_DOOR_HOLD_EN
        .door_hold                  (door_hold),
`endif
        .active_in_levels           (cin),
        .active_out_up_levels       (cup),
        .active_out_down_levels     (cdn),
        .inactivate_in_levels       (inact_in),
        .inactivate_out_up_levels   (inact_up),
        .inactivate_out_down_levels (inact_dn),
        .cur_floor                  (cur_floor),
        .motor_up                   (motor_up),
        .motor_down                 (motor_down),
        .door_open                  (door_open),
        .dir_up                     (dir_up),
        .busy                       (busy)
    );

    typedef struct packed {
        logic [2:0]  floor;
        logic        dir;
        logic [7:0]  iin;
        logic [7:0]  iup;
        logic [7:0]  idn;
        logic [15:0] cyc;
    } stop_t;

    typedef struct packed {
        logic [7:0]      cin;
        logic [7:0]      cup;
        logic [7:0]      cdn;
        logic [1:0]      nstop;
        stop_t [2:0]     stops;
    } vec_t;

    vec_t       tbl [7];
    stop_t      exp_q [$];
    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;
    int         door_run = 0;
    int         exp_door_len = 32;
    logic [7:0] p_in, p_up, p_dn;
    logic       prev_door, prev_mu, prev_md;
    logic [2:0] prev_floor;

    function automatic stop_t mk(input int f, input logic d, input logic [7:0] a,
                                 input logic [7:0] b, input logic [7:0] c, input int cy);
        stop_t s;
        s.floor = f[2:0];
        s.dir   = d;
        s.iin   = a;
        s.iup   = b;
        s.idn   = c;
        s.cyc   = cy[15:0];
        return s;
    endfunction

    function automatic vec_t mkv(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                                 input int n, input stop_t s0, input stop_t s1, input stop_t s2);
        vec_t v;
        v.cin      = a;
        v.cup      = b;
        v.cdn      = c;
        v.nstop    = n[1:0];
        v.stops[0] = s0;
        v.stops[1] = s1;
        v.stops[2] = s2;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic monitor();
        logic [7:0] oh;
        stop_t      s;
        oh = 8'b1 << cur_floor;
        chk("motor_excl", int'(motor_up & motor_down), 0);
        chk("busy_state", int'(busy), int'(motor_up | motor_down | door_open));
        if (cur_floor != prev_floor)
            chk("floor_step", int'(cur_floor),
                prev_mu ? int'(prev_floor) + 1 : (prev_md ? int'(prev_floor) - 1 : int'(prev_floor)));
        if (door_open) begin
            chk("inact_in_open", int'(inact_in), int'(oh));
            chk("inact_up_open", int'(inact_up), dir_up ? int'(oh) : 0);
            chk("inact_dn_open", int'(inact_dn), dir_up ? 0 : int'(oh));
            door_run++;
        end else begin
            chk("inact_closed", int'(inact_in | inact_up | inact_dn), 0);
            if (prev_door) begin
                chk("door_len", door_run, exp_door_len);
                door_run = 0;
            end
        end
        if (door_open && !prev_door) begin
            chk("sb_stop_pending", int'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                s = exp_q.pop_front();
                chk("stop_floor", int'(cur_floor), int'(s.floor));
                chk("stop_dir", int'(dir_up), int'(s.dir));
                chk("stop_iin", int'(inact_in), int'(s.iin));
                chk("stop_iup", int'(inact_up), int'(s.iup));
                chk("stop_idn", int'(inact_dn), int'(s.idn));
                chk("stop_cycle", cyc, int'(s.cyc));
            end
        end
    endtask

    // One clock; the call latches update with the clears seen before the edge, presses win.
    task automatic tick();
        logic [7:0] ki, ku, kd;
        logic       rst_edge;
        ki = inact_in;
        ku = inact_up;
        kd = inact_dn;
        rst_edge = !reset;
        @(posedge clk);
        #1;
        cin  = (cin & ~ki) | p_in;
        cup  = (cup & ~ku) | p_up;
        cdn  = (cdn & ~kd) | p_dn;
        p_in = '0;
        p_up = '0;
        p_dn = '0;
        cyc++;
        if (rst_edge) door_run = 0;
        else          monitor();
        prev_door  = door_open;
        prev_floor = cur_floor;
        prev_mu    = motor_up;
        prev_md    = motor_down;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        p_in  = '0;
        p_up  = '0;
        p_dn  = '0;
        tick();
        cin = '0;
        cup = '0;
        cdn = '0;
        reset = 1'b1;
        exp_q.delete();
        door_run = 0;
        exp_door_len = 32;
        cyc = 0;
    endtask

    task automatic run_idle(input int bound);
        for (int k = 0; k < bound; k++) begin
            tick();
            if (exp_q.size() == 0 && !busy) break;
        end
        chk("sb_drain", exp_q.size(), 0);
        chk("end_idle", int'(busy), 0);
        chk("calls_cleared", int'(cin | cup | cdn), 0);
    endtask

    initial begin
        reset = 1'b0;
        cin = '0; cup = '0; cdn = '0;
        p_in = '0; p_up = '0; p_dn = '0;
        prev_door = 1'b0; prev_mu = 1'b0; prev_md = 1'b0; prev_floor = '0;
`ifdef ELEVATOR_DOOR_HOLD_EN
        door_hold = 1'b0;
`endif
        do_reset();
        chk("rst_floor", int'(cur_floor), 0);
        chk("rst_dir", int'(dir_up), 1);
        chk("rst_motor_up", int'(motor_up), 0);
        chk("rst_motor_down", int'(motor_down), 0);
        chk("rst_door", int'(door_open), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_inact", int'(inact_in | inact_up | inact_dn), 0);

        // calls, then the expected stops: floor, dir, inactivate vectors, cycle of door opening
        tbl[0] = mkv(8'h01, 8'h00, 8'h00, 1, mk(0, 1'b1, 8'h01, 8'h01, 8'h00, 1), '0, '0);
        tbl[1] = mkv(8'h20, 8'h00, 8'h00, 1, mk(5, 1'b1, 8'h20, 8'h20, 8'h00, 81), '0, '0);
        tbl[2] = mkv(8'h00, 8'h00, 8'h10, 1, mk(4, 1'b0, 8'h10, 8'h00, 8'h10, 65), '0, '0);
        tbl[3] = mkv(8'h00, 8'h80, 8'h00, 1, mk(7, 1'b1, 8'h80, 8'h80, 8'h00, 113), '0, '0);
        tbl[4] = mkv(8'h00, 8'h00, 8'h01, 1, mk(0, 1'b0, 8'h01, 8'h00, 8'h01, 1), '0, '0);
        tbl[5] = mkv(8'h40, 8'h08, 8'h08, 3, mk(3, 1'b1, 8'h08, 8'h08, 8'h00, 49),
                     mk(6, 1'b1, 8'h40, 8'h40, 8'h00, 129), mk(3, 1'b0, 8'h08, 8'h00, 8'h08, 209));
        tbl[6] = mkv(8'h80, 8'h00, 8'h02, 2, mk(7, 1'b1, 8'h80, 8'h80, 8'h00, 113),
                     mk(1, 1'b0, 8'h02, 8'h00, 8'h02, 241), '0);

        for (int i = 0; i < 7; i++) begin
            do_reset();
            cin = tbl[i].cin;
            cup = tbl[i].cup;
            cdn = tbl[i].cdn;
            for (int j = 0; j < int'(tbl[i].nstop); j++) exp_q.push_back(tbl[i].stops[j]);
            run_idle(400);
        end

        // Reset while travelling up past floor 3.
        do_reset();
        cin = 8'h80;
        for (int k = 0; k < 100; k++) begin
            tick();
            if (cur_floor == 3'd3) break;
        end
        chk("mid_floor", int'(cur_floor), 3);
        chk("mid_motor", int'(motor_up), 1);
        chk("mid_cycle", cyc, 49);
        do_reset();
        chk("mid_rst_floor", int'(cur_floor), 0);
        chk("mid_rst_motor", int'(motor_up), 0);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_dir", int'(dir_up), 1);
        tick();
        chk("mid_rst_stays_idle", int'(busy), 0);

        // Reset while the door is open.
        do_reset();
        cin = 8'h01;
        exp_q.push_back(mk(0, 1'b1, 8'h01, 8'h01, 8'h00, 1));
        tick();
        chk("door_rst_pre", int'(door_open), 1);
        for (int k = 0; k < 5; k++) tick();
        do_reset();
        chk("door_rst_door", int'(door_open), 0);
        chk("door_rst_inact", int'(inact_in), 0);

        // Opposite hall call pressed while open: door re-opens with direction flipped.
        do_reset();
        cin = 8'h08;
        exp_q.push_back(mk(3, 1'b1, 8'h08, 8'h08, 8'h00, 49));
        exp_door_len = 64;
        for (int k = 0; k < 100; k++) begin
            tick();
            if (door_open) break;
        end
        chk("reentry_open", int'(door_open), 1);
        for (int k = 0; k < 10; k++) tick();
        p_dn = 8'h08;
        for (int k = 0; k < 64; k++) begin
            tick();
            if (!dir_up) break;
        end
        chk("reentry_dir", int'(dir_up), 0);
        chk("reentry_door", int'(door_open), 1);
        chk("reentry_cycle", cyc, 81);
        chk("reentry_idn", int'(inact_dn), 8'h08);
        run_idle(200);

`ifdef ELEVATOR_DOOR_HOLD_EN
        // Hold the door for 50 cycles from its first open cycle.
        do_reset();
        cin = 8'h01;
        exp_q.push_back(mk(0, 1'b1, 8'h01, 8'h01, 8'h00, 1));
        exp_door_len = 82;
        tick();
        door_hold = 1'b1;
        for (int k = 0; k < 50; k++) tick();
        door_hold = 1'b0;
        chk("hold_still_open", int'(door_open), 1);
        run_idle(200);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
